// File: rtl/imem_loader.sv
// imem_loader
//
// Program loader that fills the byte-addressed instruction memory before the
// CPU runs. Each 32-bit instruction word is accepted on a valid/ready stream.
// It is then written as four byte writes in little-endian order: byte base+0
// receives bits [7:0] and byte base+3 receives bits [31:24]. A fetch of
// {Mem[PC+3],Mem[PC+2],Mem[PC+1],Mem[PC]} therefore returns the original word.
//
// Parameters:
//   MEM_BYTES  memory capacity in bytes (multiple of 4)
//   ADDR_W     width of mem_addr (matches PC width)
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-low reset
//   start      one-cycle pulse: begin a load at byte address 0
//   in_valid   in_word / in_last valid
//   in_ready   loader accepts a word this cycle
//   in_word    instruction word
//   in_last    marks the final word of the program
//   mem_we     byte write enable to instruction memory
//   mem_addr   byte address of the current write
//   mem_wdata  byte to write
//   busy       load in progress (waiting for a word or writing one)
//   done       load finished; held until the next start or reset
//   overflow   memory filled without seeing in_last; held like done

module imem_loader #(
    parameter int MEM_BYTES = 36,
    parameter int ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_word,
    input  logic              in_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              overflow
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_WORD,
        WRITE,
        DONE
    } state_t;

    // Base address at which the last word slot ends; reaching it means full.
    localparam logic [ADDR_W-1:0] MEM_LIMIT = ADDR_W'(MEM_BYTES);

    state_t            state, state_next;
    logic [ADDR_W-1:0] base, base_next;
    logic [1:0]        idx, idx_next;
    logic [31:0]       word, word_next;
    logic              last, last_next;
    logic              done_next;
    logic              overflow_next;
    logic [ADDR_W-1:0] base_plus4;

    assign base_plus4 = base + ADDR_W'(4);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            base     <= '0;
            idx      <= '0;
            word     <= '0;
            last     <= 1'b0;
            done     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state    <= state_next;
            base     <= base_next;
            idx      <= idx_next;
            word     <= word_next;
            last     <= last_next;
            done     <= done_next;
            overflow <= overflow_next;
        end
    end

    // Next-state logic. Because in_ready is exactly (state == WAIT_WORD),
    // a handshake in WAIT_WORD reduces to in_valid alone. start is only
    // honoured in IDLE and DONE, so a stray pulse mid-load cannot restart
    // the address sequence.
    always_comb begin
        state_next    = state;
        base_next     = base;
        idx_next      = idx;
        word_next     = word;
        last_next     = last;
        done_next     = done;
        overflow_next = overflow;

        case (state)
            IDLE: begin
                if (start) begin
                    state_next = WAIT_WORD;
                    base_next  = '0;
                end
            end

            WAIT_WORD: begin
                if (in_valid) begin
                    word_next  = in_word;
                    last_next  = in_last;
                    idx_next   = 2'd0;
                    state_next = WRITE;
                end
            end

            WRITE: begin
                // idx wraps from 3 back to 0, ready for the next word.
                idx_next = idx + 2'd1;
                if (idx == 2'd3) begin
                    base_next = base_plus4;
                    // in_last wins over the full check, so a final word that
                    // also fills the last slot ends cleanly without overflow.
                    if (last) begin
                        state_next = DONE;
                        done_next  = 1'b1;
                    end else if (base_plus4 == MEM_LIMIT) begin
                        state_next    = DONE;
                        done_next     = 1'b1;
                        overflow_next = 1'b1;
                    end else begin
                        state_next = WAIT_WORD;
                    end
                end
            end

            DONE: begin
                if (start) begin
                    state_next    = WAIT_WORD;
                    base_next     = '0;
                    done_next     = 1'b0;
                    overflow_next = 1'b0;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Byte lane selection: idx 0 drives the least significant byte.
    always_comb begin
        mem_wdata = word[7:0];
        case (idx)
            2'd0:    mem_wdata = word[7:0];
            2'd1:    mem_wdata = word[15:8];
            2'd2:    mem_wdata = word[23:16];
            default: mem_wdata = word[31:24];
        endcase
    end

    assign in_ready = (state == WAIT_WORD);
    assign mem_we   = (state == WRITE);
    assign busy     = (state == WAIT_WORD) || (state == WRITE);
    assign mem_addr = base + ADDR_W'(idx);

endmodule

// File: doc/imem_loader.md
# imem_loader

Program loader that fills the byte-addressed instruction memory before the CPU runs. Each 32-bit instruction word arrives on a valid/ready stream and is written as four byte writes in little-endian order. Byte addr+0 gets bits [7:0] and addr+3 gets bits [31:24], so a fetch of {Mem[PC+3],Mem[PC+2],Mem[PC+1],Mem[PC]} returns the original word. The block sits between the host/test source and the write port of the instruction byte memory; `busy` holds the core in reset/stall while loading.

## Interface
- MEM_BYTES, 36, memory capacity in bytes; must be a multiple of 4.
- ADDR_W, 32, width of `mem_addr`; matches PC width.

- clk  in  1  rising-edge clock
- reset  in  1  reset, synchronous, active-low
- start  in  1  one-cycle pulse: begin a load at byte address 0
- in_valid  in  1  `in_word` / `in_last` valid
- in_ready  out  1  loader accepts a word this cycle
- in_word  in  32  instruction word
- in_last  in  1  marks the final word of the program
- mem_we  out  1  byte write enable to instruction memory
- mem_addr  out  ADDR_W  byte address of current write
- mem_wdata  out  8  byte to write
- busy  out  1  load in progress (WAIT_WORD or WRITE)
- done  out  1  load finished; held until next start or reset
- overflow  out  1  memory filled without seeing `in_last`; held like `done`

## Operation
- States: IDLE, WAIT_WORD, WRITE, DONE.
- Registers: `base` (word-aligned byte address), `idx` (2-bit byte index), `word` (captured data), `last` (captured flag).
- All outputs decode from registers only; there are no input-to-output combinational paths.
  - `in_ready` = (state==WAIT_WORD).
  - `mem_we` = (state==WRITE).
  - `mem_addr` = base+idx.
  - `mem_wdata` = word[8*idx+7 : 8*idx].
  - `busy` = WAIT_WORD or WRITE.
- Reset (reset==0 at a rising edge): state IDLE, base=0, idx=0, word=0, last=0, done=0, overflow=0. Every output is therefore 0.
- IDLE: on `start`, go to WAIT_WORD with base=0.
- WAIT_WORD: when in_valid&&in_ready, capture `in_word` and `in_last`, set idx=0, and go to WRITE. With no valid, the block stays in WAIT_WORD indefinitely.
- WRITE: one byte per cycle with idx counting 0,1,2,3. At idx==3:
  - base += 4.
  - If last==1, go to DONE with done=1.
  - Else if base+4 == MEM_BYTES, go to DONE with done=1 and overflow=1.
  - Else return to WAIT_WORD.
- DONE: `in_ready`=0, so extra words are not consumed. On `start`, clear done and overflow, set base=0, and go to WAIT_WORD.
- `start` in WAIT_WORD or WRITE is ignored.
- A word carrying in_last that also fills the last slot gives done=1, overflow=0.
- Address arithmetic is unsigned ADDR_W; base never exceeds MEM_BYTES-4 while writing, so no wrap-around is possible.

## Timing
- Handshake completes at edge E. Byte writes are presented during cycles E..E+3 and captured by memory at edges E+1..E+4.
- `in_ready` rises again in the cycle after edge E+4, giving 5 cycles per word at full rate.
- `done`/`busy` update in the cycle after the final byte write, i.e. after edge E+4 of the last word.
- `start` to first `in_ready`=1: one cycle.
- Reset mid-WRITE: `mem_we` is 0 in the cycle after the reset edge. A partially written word stays partially written, and the next `start` reloads from address 0.
- Reset has priority over `start` and over the handshake in the same cycle.

## Test plan
- Reset: hold reset=0 for 2 cycles with start=1 and in_valid=1 → every output is 0 and no `mem_we` pulse occurs.
- Seven-word program, no stalls:
  - Words 00011020, 00853022, 01095024, 01285025, 01660180, 01A90282, FC20000D, with in_last on the seventh.
  - Required: Mem[0..3]=20,10,01,00; Mem[24..27]=0D,00,20,FC.
  - Exactly 28 `mem_we` cycles; done=1, overflow=0.
- Fill without last: 9 words, in_last=0 throughout → 36 writes, done=1, overflow=1. A 10th word held with in_valid=1 sees `in_ready`=0 forever.
- Backpressure: in_valid deasserted for 3 cycles between words 2 and 3 → FSM stays in WAIT_WORD, `mem_we`=0, and the byte sequence is unchanged.
- Reset mid-word: assert reset=0 while idx==2 of word 3 → next cycle mem_we=0 and state is IDLE. A following start plus one word 0000ABCD writes CD,AB,00,00 to addresses 0..3.
- Start handling:
  - `start` pulsed during WRITE → ignored, and base continues as before.
  - `start` in DONE → done drops the next cycle, `in_ready`=1, and the first write goes to address 0.
